// File: rtl/csr_regfile.sv
// Machine-mode CSR register file: combinational reads, registered writes,
// trap-entry / mret side effects on mstatus/mepc/mcause, and mcycle/minstret.
module csr_regfile #(
  parameter int                XLEN          = 64,
  parameter logic [XLEN-1:0]   MSTATUS_RESET = 64'h0000_000a_0000_1800,
  parameter logic [XLEN-1:0]   MTVEC_RESET   = 64'h0,
  parameter logic [XLEN-1:0]   MISA_VALUE    = 64'h8000_0000_0000_0100
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [11:0]     csr_read_addr,
  output logic [XLEN-1:0] csr_read_data,
  output logic            csr_read_illegal,
  input  logic            csr_write_en,
  input  logic [11:0]     csr_write_addr,
  input  logic [XLEN-1:0] csr_write_data,
  output logic            csr_write_illegal,
  input  logic            trap_en,
  input  logic [XLEN-1:0] trap_cause,
  input  logic [XLEN-1:0] trap_pc,
  input  logic            mret_en,
  input  logic            instret_en,
  output logic [XLEN-1:0] mtvec_out,
  output logic [XLEN-1:0] mepc_out,
  output logic [XLEN-1:0] mstatus_out
);

  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MISA     = 12'h301;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
  localparam logic [11:0] ADDR_MINSTRET = 12'hB02;
  localparam logic [11:0] ADDR_MHARTID  = 12'hF14;

  // Word-aligned PCs and trap vectors: low two bits are always zero.
  localparam logic [XLEN-1:0] ALIGN_MASK = ~64'h3;

  // Only MIE and MPIE are stored; every other mstatus bit (including MPP,
  // fixed at M-mode) is taken from the reset constant.
  function automatic logic [XLEN-1:0] mstatus_compose(input logic mie, input logic mpie);
    logic [XLEN-1:0] v;
    v    = MSTATUS_RESET;
    v[3] = mie;
    v[7] = mpie;
    return v;
  endfunction

  logic            mie_q, mie_d;
  logic            mpie_q, mpie_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d;
  logic [XLEN-1:0] mscratch_q, mscratch_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
  logic [XLEN-1:0] mcycle_q, mcycle_d;
  logic [XLEN-1:0] minstret_q, minstret_d;
  logic            wr_ok_s;

  // Write legality: only the seven writable CSRs accept a write.
  always_comb begin
    case (csr_write_addr)
      ADDR_MSTATUS, ADDR_MTVEC, ADDR_MSCRATCH, ADDR_MEPC,
      ADDR_MCAUSE, ADDR_MCYCLE, ADDR_MINSTRET: csr_write_illegal = 1'b0;
      default:                                 csr_write_illegal = csr_write_en;
    endcase
    wr_ok_s = csr_write_en & ~csr_write_illegal;
  end

  // Read mux from current state; unimplemented addresses read zero.
  always_comb begin
    csr_read_illegal = 1'b0;
    case (csr_read_addr)
      ADDR_MSTATUS:  csr_read_data = mstatus_compose(mie_q, mpie_q);
      ADDR_MISA:     csr_read_data = MISA_VALUE;
      ADDR_MTVEC:    csr_read_data = mtvec_q;
      ADDR_MSCRATCH: csr_read_data = mscratch_q;
      ADDR_MEPC:     csr_read_data = mepc_q;
      ADDR_MCAUSE:   csr_read_data = mcause_q;
      ADDR_MCYCLE:   csr_read_data = mcycle_q;
      ADDR_MINSTRET: csr_read_data = minstret_q;
      ADDR_MHARTID:  csr_read_data = 64'h0;
      default: begin
        csr_read_data    = 64'h0;
        csr_read_illegal = 1'b1;
      end
    endcase
  end

  // Next-state: trap beats mret beats CSR write on the registers they share.
  always_comb begin
    mie_d      = mie_q;
    mpie_d     = mpie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;

    if (trap_en) begin
      mpie_d = mie_q;
      mie_d  = 1'b0;
    end else if (mret_en) begin
      mie_d  = mpie_q;
      mpie_d = 1'b1;
    end else if (wr_ok_s && csr_write_addr == ADDR_MSTATUS) begin
      mie_d  = csr_write_data[3];
      mpie_d = csr_write_data[7];
    end else begin
      mie_d  = mie_q;
    end

    if (trap_en) begin
      mepc_d   = trap_pc & ALIGN_MASK;
      mcause_d = trap_cause;
    end else if (wr_ok_s && csr_write_addr == ADDR_MEPC) begin
      mepc_d   = csr_write_data & ALIGN_MASK;
    end else if (wr_ok_s && csr_write_addr == ADDR_MCAUSE) begin
      mcause_d = csr_write_data;
    end else begin
      mepc_d   = mepc_q;
    end

    if (wr_ok_s && csr_write_addr == ADDR_MTVEC) begin
      mtvec_d = csr_write_data & ALIGN_MASK;
    end else begin
      mtvec_d = mtvec_q;
    end

    if (wr_ok_s && csr_write_addr == ADDR_MSCRATCH) begin
      mscratch_d = csr_write_data;
    end else begin
      mscratch_d = mscratch_q;
    end

    if (wr_ok_s && csr_write_addr == ADDR_MCYCLE) begin
      mcycle_d = csr_write_data;
    end else begin
      mcycle_d = mcycle_q + 64'd1;
    end

    if (wr_ok_s && csr_write_addr == ADDR_MINSTRET) begin
      minstret_d = csr_write_data;
    end else begin
      minstret_d = minstret_q + {63'd0, instret_en};
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mie_q      <= MSTATUS_RESET[3];
      mpie_q     <= MSTATUS_RESET[7];
      mtvec_q    <= MTVEC_RESET;
      mscratch_q <= 64'h0;
      mepc_q     <= 64'h0;
      mcause_q   <= 64'h0;
      mcycle_q   <= 64'h0;
      minstret_q <= 64'h0;
    end else begin
      mie_q      <= mie_d;
      mpie_q     <= mpie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
    end
  end

  assign mtvec_out   = mtvec_q;
  assign mepc_out    = mepc_q;
  assign mstatus_out = mstatus_compose(mie_q, mpie_q);

endmodule

// File: tb/tb_csr_regfile.sv
// Directed bench for csr_regfile: a reference model of the architectural CSR
// state checked every negedge, plus hand-computed literal expectations.
module tb_csr_regfile;

  localparam logic [63:0] MS_RST = 64'h0000_000a_0000_1800;
  localparam logic [63:0] MISA   = 64'h8000_0000_0000_0100;
  localparam logic [63:0] WMASK  = 64'h88;

  logic        clk, rst_n;
  logic [11:0] csr_read_addr;
  logic [63:0] csr_read_data;
  logic        csr_read_illegal;
  logic        csr_write_en;
  logic [11:0] csr_write_addr;
  logic [63:0] csr_write_data;
  logic        csr_write_illegal;
  logic        trap_en;
  logic [63:0] trap_cause, trap_pc;
  logic        mret_en, instret_en;
  logic [63:0] mtvec_out, mepc_out, mstatus_out;

  int checks = 0;
  int errors = 0;

  csr_regfile dut (
    .clk(clk), .rst_n(rst_n),
    .csr_read_addr(csr_read_addr), .csr_read_data(csr_read_data),
    .csr_read_illegal(csr_read_illegal),
    .csr_write_en(csr_write_en), .csr_write_addr(csr_write_addr),
    .csr_write_data(csr_write_data), .csr_write_illegal(csr_write_illegal),
    .trap_en(trap_en), .trap_cause(trap_cause), .trap_pc(trap_pc),
    .mret_en(mret_en), .instret_en(instret_en),
    .mtvec_out(mtvec_out), .mepc_out(mepc_out), .mstatus_out(mstatus_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [63:0] m_mstatus, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mcycle, m_minstret;

  function automatic bit m_writable(input logic [11:0] a);
    return (a == 12'h300) || (a == 12'h305) || (a == 12'h340) || (a == 12'h341) ||
           (a == 12'h342) || (a == 12'hB00) || (a == 12'hB02);
  endfunction

  function automatic logic [64:0] m_read(input logic [11:0] a);
    // {illegal, data}
    case (a)
      12'h300: return {1'b0, m_mstatus};
      12'h301: return {1'b0, MISA};
      12'h305: return {1'b0, m_mtvec};
      12'h340: return {1'b0, m_mscratch};
      12'h341: return {1'b0, m_mepc};
      12'h342: return {1'b0, m_mcause};
      12'hB00: return {1'b0, m_mcycle};
      12'hB02: return {1'b0, m_minstret};
      12'hF14: return {1'b0, 64'h0};
      default: return {1'b1, 64'h0};
    endcase
  endfunction

  // Model state update at each clock edge, cleared asynchronously by reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mstatus = MS_RST; m_mtvec = 64'h0; m_mscratch = 64'h0; m_mepc = 64'h0;
      m_mcause = 64'h0; m_mcycle = 64'h0; m_minstret = 64'h0;
    end else begin
      bit w;
      w = csr_write_en && m_writable(csr_write_addr);
      if (trap_en)
        m_mstatus = (MS_RST & ~WMASK) | ((m_mstatus & 64'h8) << 4);
      else if (mret_en)
        m_mstatus = (MS_RST & ~WMASK) | 64'h80 | ((m_mstatus & 64'h80) >> 4);
      else if (w && csr_write_addr == 12'h300)
        m_mstatus = (MS_RST & ~WMASK) | (csr_write_data & WMASK);
      if (trap_en) begin
        m_mepc = {trap_pc[63:2], 2'b00};
        m_mcause = trap_cause;
      end else begin
        if (w && csr_write_addr == 12'h341) m_mepc = {csr_write_data[63:2], 2'b00};
        if (w && csr_write_addr == 12'h342) m_mcause = csr_write_data;
      end
      if (w && csr_write_addr == 12'h305) m_mtvec = {csr_write_data[63:2], 2'b00};
      if (w && csr_write_addr == 12'h340) m_mscratch = csr_write_data;
      m_mcycle = (w && csr_write_addr == 12'hB00) ? csr_write_data : m_mcycle + 1;
      if (w && csr_write_addr == 12'hB02) m_minstret = csr_write_data;
      else if (instret_en) m_minstret = m_minstret + 1;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    logic [64:0] r;
    r = m_read(csr_read_addr);
    chk("cmp_read_data", csr_read_data, r[63:0]);
    chk("cmp_read_illegal", {63'd0, csr_read_illegal}, {63'd0, r[64]});
    chk("cmp_write_illegal", {63'd0, csr_write_illegal},
        {63'd0, csr_write_en && !m_writable(csr_write_addr)});
    chk("cmp_mtvec_out", mtvec_out, m_mtvec);
    chk("cmp_mepc_out", mepc_out, m_mepc);
    chk("cmp_mstatus_out", mstatus_out, m_mstatus);
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    csr_write_en = 1'b0; trap_en = 1'b0; mret_en = 1'b0; instret_en = 1'b0;
  endtask

  task automatic wr(input logic [11:0] a, input logic [63:0] d);
    csr_write_en = 1'b1; csr_write_addr = a; csr_write_data = d;
  endtask

  task automatic rd(input string nm, input logic [11:0] a, input logic [63:0] exp);
    csr_read_addr = a;
    #1;
    chk(nm, csr_read_data, exp);
  endtask

  initial begin
    rst_n = 1'b0; idle();
    csr_read_addr = 12'h300; csr_write_addr = 12'h0; csr_write_data = 64'h0;
    trap_cause = 64'h0; trap_pc = 64'h0;
    #2;
    rd("rst_mstatus", 12'h300, 64'ha00001800);
    rd("rst_misa", 12'h301, 64'h8000000000000100);
    rd("rst_mtvec", 12'h305, 64'h0);
    rd("rst_mscratch", 12'h340, 64'h0);
    rd("rst_mepc", 12'h341, 64'h0);
    rd("rst_mcause", 12'h342, 64'h0);
    rd("rst_mcycle", 12'hB00, 64'h0);
    rd("rst_minstret", 12'hB02, 64'h0);
    rd("rst_mhartid", 12'hF14, 64'h0);
    rd("rst_unimpl", 12'h7C0, 64'h0);
    chk("rst_unimpl_illegal", {63'd0, csr_read_illegal}, 64'd1);
    step(); rst_n = 1'b1;

    // mtvec alignment and mstatus write mask
    wr(12'h305, 64'h8000_0103); step(); idle();
    rd("mtvec_align", 12'h305, 64'h8000_0100);
    chk("mtvec_out", mtvec_out, 64'h8000_0100);
    wr(12'h300, 64'hFFFF_FFFF_FFFF_FFFF); step(); idle();
    rd("mstatus_ones", 12'h300, 64'ha00001888);

    // trap entry with MIE=1
    trap_en = 1'b1; trap_pc = 64'h8000_0010; trap_cause = 64'd11; step(); idle();
    rd("trap_mepc", 12'h341, 64'h8000_0010);
    rd("trap_mcause", 12'h342, 64'd11);
    rd("trap_mstatus", 12'h300, 64'ha00001880);

    // mret restores MIE from MPIE
    mret_en = 1'b1; step(); idle();
    rd("mret_mstatus", 12'h300, 64'ha00001888);
    chk("mret_mepc_out", mepc_out, 64'h8000_0010);

    // trap beats same-cycle mepc write
    trap_en = 1'b1; trap_pc = 64'h100; wr(12'h341, 64'h200); step(); idle();
    rd("trap_vs_wr_mepc", 12'h341, 64'h100);
    rd("trap2_mstatus", 12'h300, 64'ha00001880);

    // write to untouched mscratch commits during a trap
    trap_en = 1'b1; trap_pc = 64'h104; wr(12'h340, 64'd5); step(); idle();
    rd("trap_wr_mscratch", 12'h340, 64'd5);
    rd("trap3_mepc", 12'h341, 64'h104);
    rd("trap3_mstatus", 12'h300, 64'ha00001800);

    // mret beats same-cycle mstatus write
    mret_en = 1'b1; wr(12'h300, 64'h8); step(); idle();
    rd("mret_vs_wr_mstatus", 12'h300, 64'ha00001880);

    // mepc write alignment and mcause write
    wr(12'h341, 64'h203); step(); idle();
    rd("mepc_align", 12'h341, 64'h200);
    wr(12'h342, 64'h8000_0000_0000_0007); step(); idle();
    rd("mcause_wr", 12'h342, 64'h8000_0000_0000_0007);

    // mcycle wrap
    wr(12'hB00, 64'hFFFF_FFFF_FFFF_FFFF); step(); idle();
    rd("mcycle_loaded", 12'hB00, 64'hFFFF_FFFF_FFFF_FFFF);
    step(); rd("mcycle_wrap0", 12'hB00, 64'h0);
    step(); rd("mcycle_wrap1", 12'hB00, 64'h1);

    // minstret write beats increment
    wr(12'hB02, 64'd7); instret_en = 1'b1; step(); idle();
    rd("minstret_wr", 12'hB02, 64'd7);
    instret_en = 1'b1; step(); idle();
    rd("minstret_inc", 12'hB02, 64'd8);
    step(); rd("minstret_hold", 12'hB02, 64'd8);

    // illegal writes: read-only and unimplemented addresses
    wr(12'hF14, 64'h55); #1;
    chk("wr_illegal_mhartid", {63'd0, csr_write_illegal}, 64'd1);
    step(); idle();
    rd("mhartid_still0", 12'hF14, 64'h0);
    wr(12'h301, 64'h0); #1;
    chk("wr_illegal_misa", {63'd0, csr_write_illegal}, 64'd1);
    step(); idle();
    rd("misa_unchanged", 12'h301, 64'h8000000000000100);
    wr(12'h340, 64'h9); #1;
    chk("wr_legal_mscratch", {63'd0, csr_write_illegal}, 64'd0);
    step(); idle();

    // asynchronous reset during a trap
    trap_en = 1'b1; trap_pc = 64'h400; trap_cause = 64'd11; #1;
    rst_n = 1'b0; #1;
    chk("arst_mepc_out", mepc_out, 64'h0);
    chk("arst_mstatus_out", mstatus_out, 64'ha00001800);
    rd("arst_mcause", 12'h342, 64'h0);
    rd("arst_mscratch", 12'h340, 64'h0);
    step();
    chk("arst_hold_mepc", mepc_out, 64'h0);
    idle(); rst_n = 1'b1;
    step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
